noc_link_rx_deserializer: RTL



---
 rtl/noc_link_rx_deserializer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/noc_link_rx_deserializer.sv
// Receive endpoint of a credit-based NoC link: buffers flits, returns one credit
// per consumed flit and reassembles SERIALIZATION_FACTOR flits into an AXI-stream word.
module noc_link_rx_deserializer #(
  parameter int FLIT_BUFFER_DEPTH    = 4,
  parameter int TDATA_WIDTH          = 32,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
  parameter int LEVEL_WIDTH          = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                   clk_noc,
  input  logic                   rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  output logic                   err_overflow,
  output logic                   err_short,
  output logic                   err_dest,
  output logic [LEVEL_WIDTH-1:0] fifo_level
);

  localparam int PTR_W   = $clog2(FLIT_BUFFER_DEPTH);
  localparam int LANE_W  = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [LANE_W-1:0]      LAST_LANE  = LANE_W'(SERIALIZATION_FACTOR - 1);
  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(FLIT_BUFFER_DEPTH);

  logic [ENTRY_W-1:0]     mem_q [FLIT_BUFFER_DEPTH];
  logic [PTR_W-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LEVEL_WIDTH-1:0] count_q, count_d;
  logic [FLIT_WIDTH-1:0]  headData;
  logic [DEST_WIDTH-1:0]  headDest;
  logic                   headTail;
  logic                   fifoEmpty, fifoFull, push, pop;

  logic [LANE_W-1:0]      laneCnt_q, laneCnt_d;
  logic [TDATA_WIDTH-1:0] word_q, word_d;
  logic [DEST_WIDTH-1:0]  destCap_q, destCap_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d, credit_q;
  logic                   errOverflow_q, errOverflow_d;
  logic                   errShort_q, errShort_d;
  logic                   errDest_q, errDest_d;

  assign {headData, headDest, headTail} = mem_q[rdPtr_q];
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == FULL_LEVEL);
  assign pop       = !fifoEmpty && (!tvalid_q || axis_out_tready);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = send_in && (!fifoFull || pop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LEVEL_WIDTH'(1);
      2'b01:   count_d = count_q - LEVEL_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    laneCnt_d     = laneCnt_q;
    word_d        = word_q;
    destCap_d     = destCap_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    errOverflow_d = errOverflow_q | (send_in && fifoFull && !pop);
    errShort_d    = errShort_q;
    errDest_d     = errDest_q;

    if (tvalid_q && axis_out_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    if (pop) begin
      if (laneCnt_q == '0) begin
        word_d                   = '0;
        word_d[FLIT_WIDTH-1:0]   = headData;
        destCap_d                = headDest;
      end else begin
        for (int l = 1; l < SERIALIZATION_FACTOR; l++) begin
          if (laneCnt_q == LANE_W'(l)) word_d[l*FLIT_WIDTH +: FLIT_WIDTH] = headData;
        end
        if (headDest != destCap_q) errDest_d = 1'b1;
      end

      if (headTail || laneCnt_q == LAST_LANE) begin
        tvalid_d  = 1'b1;
        tlast_d   = headTail;
        laneCnt_d = '0;
        if (laneCnt_q != LAST_LANE) errShort_d = 1'b1;
      end else begin
        laneCnt_d = laneCnt_q + LANE_W'(1);
      end
    end
  end

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk_noc) begin
    if (push) mem_q[wrPtr_q] <= {data_in, dest_in, is_tail_in};
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      laneCnt_q     <= '0;
      word_q        <= '0;
      destCap_q     <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      credit_q      <= 1'b0;
      errOverflow_q <= 1'b0;
      errShort_q    <= 1'b0;
      errDest_q     <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      laneCnt_q     <= laneCnt_d;
      word_q        <= word_d;
      destCap_q     <= destCap_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      credit_q      <= pop;
      errOverflow_q <= errOverflow_d;
      errShort_q    <= errShort_d;
      errDest_q     <= errDest_d;
    end
  end

  // Word and dest are masked while invalid so partial assembly never leaks out.
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tdata  = tvalid_q ? word_q : '0;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tid    = tvalid_q ? destCap_q[DEST_WIDTH-1:TDEST_WIDTH] : '0;
  assign axis_out_tdest  = tvalid_q ? destCap_q[TDEST_WIDTH-1:0] : '0;
  assign credit_out      = credit_q;
  assign err_overflow    = errOverflow_q;
  assign err_short       = errShort_q;
  assign err_dest        = errDest_q;
  assign fifo_level      = count_q;

endmodule
